// File: rtl/la_iosupply_pkg.sv
`default_nettype none
// ============================================================================
// Module      : la_iosupply_pkg
// Description : Shared encodings and helpers for the IO-ring supply sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package la_iosupply_pkg;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_pwrup     = 3'd1;
    localparam logic [2:0] c_st_settle_up = 3'd2;
    localparam logic [2:0] c_st_release   = 3'd3;
    localparam logic [2:0] c_st_up        = 3'd4;
    localparam logic [2:0] c_st_pwrdn     = 3'd5;
    localparam logic [2:0] c_st_fault     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = c_st_idle,
        ST_PWRUP     = c_st_pwrup,
        ST_SETTLE_UP = c_st_settle_up,
        ST_RELEASE   = c_st_release,
        ST_UP        = c_st_up,
        ST_PWRDN     = c_st_pwrdn,
        ST_FAULT     = c_st_fault
    } state_t;

    // ring_ctrl layout: seg_en in the low bits, then iso, then ready
    function automatic int iso_bit(input int nseg);
        return nseg;
    endfunction

    function automatic int ready_bit(input int nseg);
        return nseg + 1;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/la_iosync.sv
`default_nettype none
// ============================================================================
// Module      : la_iosync
// Description : W-bit two-flop synchroniser, synchronous reset to zero.
// Revision    : 1.0  initial release
// ============================================================================
module la_iosync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/la_iosupply_seq.sv
`default_nettype none
// ============================================================================
// Module      : la_iosupply_seq
// Description : IO-ring supply sequencer: ordered power-up with power-good
//               timeout and settle, reverse power-down, latched faults.
// Revision    : 1.0  initial release
// ============================================================================
module la_iosupply_seq
    import la_iosupply_pkg::*;
#(
    parameter int NSEG    = 3,
    parameter int RINGW   = 8,
    parameter int CNTW    = 8,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [NSEG-1:0]  pgood,
    output logic [NSEG-1:0]  seg_en,
    output logic             iso,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       fault_seg,
    output logic [RINGW-1:0] ring_ctrl
);

    localparam int              c_iso_bit     = iso_bit(NSEG);
    localparam int              c_ready_bit   = ready_bit(NSEG);
    localparam logic [CNTW-1:0] c_to_last     = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] c_settle_last = CNTW'(SETTLE - 1);
    localparam logic [2:0]      c_idx_last    = 3'(NSEG - 1);

    state_t            r_state;
    logic [2:0]        r_idx;
    logic [CNTW-1:0]   r_cnt;
    logic [NSEG-1:0]   r_seg_en;
    logic              r_iso;
    logic              r_ready;
    logic              r_fault;
    logic [2:0]        r_fault_seg;

    logic [NSEG-1:0]   w_pg_s;
    logic [NSEG-1:0]   w_lt;
    logic [NSEG-1:0]   w_le;
    logic [NSEG-1:0]   w_at;
    logic              w_pg_cur;
    logic              w_fault_req;
    logic [2:0]        w_fault_idx;

    la_iosync #(
        .W (NSEG)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pgood),
        .o_sync  (w_pg_s)
    );

    // Segment masks relative to the current step index
    for (genvar j = 0; j < NSEG; j++) begin : g_mask
        assign w_lt[j] = (3'(j) <  r_idx);
        assign w_le[j] = (3'(j) <= r_idx);
        assign w_at[j] = (3'(j) == r_idx);
    end

    assign w_pg_cur = |(w_pg_s & w_at);

    always_comb begin
        w_fault_req = 1'b0;
        w_fault_idx = 3'd0;
        case (r_state)
            ST_PWRUP: begin
                if (|(~w_pg_s & w_lt)) begin
                    w_fault_req = 1'b1;
                    w_fault_idx = lowest_set(8'(~w_pg_s & w_lt));
                end else if (!w_pg_cur && (r_cnt == c_to_last)) begin
                    w_fault_req = 1'b1;
                    w_fault_idx = r_idx;
                end
            end
            ST_SETTLE_UP: begin
                if (|(~w_pg_s & w_le)) begin
                    w_fault_req = 1'b1;
                    w_fault_idx = lowest_set(8'(~w_pg_s & w_le));
                end
            end
            ST_RELEASE, ST_UP: begin
                if (|(~w_pg_s)) begin
                    w_fault_req = 1'b1;
                    w_fault_idx = lowest_set(8'(~w_pg_s));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_seg_en    <= '0;
            r_iso       <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_seg <= '0;
        end else if (w_fault_req) begin
            // Fault takes priority over any concurrent stop request
            r_state     <= ST_FAULT;
            r_cnt       <= '0;
            r_seg_en    <= '0;
            r_iso       <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b1;
            r_fault_seg <= w_fault_idx;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_PWRUP;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_seg_en <= NSEG'(1);
                    end
                end
                ST_PWRUP: begin
                    if (w_pg_cur) begin
                        r_state <= ST_SETTLE_UP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SETTLE_UP: begin
                    if (r_cnt == c_settle_last) begin
                        r_cnt <= '0;
                        if (r_idx < c_idx_last) begin
                            r_idx    <= r_idx + 1'b1;
                            r_seg_en <= (r_seg_en << 1) | NSEG'(1);
                            r_state  <= ST_PWRUP;
                        end else begin
                            r_state <= ST_RELEASE;
                            r_iso   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_UP;
                    r_ready <= 1'b1;
                end
                ST_UP: begin
                    if (stop) begin
                        r_state <= ST_PWRDN;
                        r_iso   <= 1'b1;
                        r_ready <= 1'b0;
                        r_idx   <= c_idx_last;
                        r_cnt   <= '0;
                    end
                end
                ST_PWRDN: begin
                    if (r_cnt == c_settle_last) begin
                        r_cnt    <= '0;
                        r_seg_en <= r_seg_en >> 1;
                        if (r_idx == 3'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (clear) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign seg_en    = r_seg_en;
    assign iso       = r_iso;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign fault_seg = r_fault_seg;

    always_comb begin
        ring_ctrl              = '0;
        ring_ctrl[NSEG-1:0]    = r_seg_en;
        ring_ctrl[c_iso_bit]   = r_iso;
        ring_ctrl[c_ready_bit] = r_ready;
    end

endmodule
`default_nettype wire

// File: tb/tb_la_iosupply_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_iosupply_seq
// Description : Scoreboard bench for la_iosupply_seq (NSEG=3, SETTLE=4, TIMEOUT=16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_la_iosupply_seq;

    localparam int NSEG    = 3;
    localparam int RINGW   = 8;
    localparam int CNTW    = 8;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 16;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic             clear = 1'b0;
    logic [NSEG-1:0]  pgood;
    logic [NSEG-1:0]  seg_en;
    logic             iso;
    logic             ready;
    logic             fault;
    logic [2:0]       fault_seg;
    logic [RINGW-1:0] ring_ctrl;

    logic [NSEG-1:0]  pg_model = '0;
    logic [NSEG-1:0]  allow    = '1;
    logic [NSEG-1:0]  drop     = '0;
    int               pg_cnt [NSEG];

    logic [NSEG-1:0]  exp_q [$];
    logic [NSEG-1:0]  prev_seg = '0;
    bit               mon_en   = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    assign pgood = pg_model & allow & ~drop;

    always #5 clk = ~clk;

    la_iosupply_seq #(
        .NSEG    (NSEG),
        .RINGW   (RINGW),
        .CNTW    (CNTW),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .pgood     (pgood),
        .seg_en    (seg_en),
        .iso       (iso),
        .ready     (ready),
        .fault     (fault),
        .fault_seg (fault_seg),
        .ring_ctrl (ring_ctrl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!ready && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic wait_seg(input string tag, input logic [NSEG-1:0] v);
        int k = 0;
        while (seg_en !== v && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 32'(seg_en), 32'(v));
    endtask

    task automatic power_up(input string tag);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(tag);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Supply model: a segment reports good 3 cycles after its switch closes
    always @(negedge clk) begin
        for (int i = 0; i < NSEG; i++) begin
            if (seg_en[i] === 1'b1) begin
                pg_cnt[i]   <= (pg_cnt[i] < 3) ? pg_cnt[i] + 1 : 3;
                pg_model[i] <= (pg_cnt[i] >= 2);
            end else begin
                pg_cnt[i]   <= 0;
                pg_model[i] <= 1'b0;
            end
        end
    end

    // Every seg_en change must match the next queued expectation
    always @(posedge clk) begin
        #1;
        if (mon_en && seg_en !== prev_seg) begin
            if (exp_q.size() > 0) chk("seg_seq", 32'(seg_en), 32'(exp_q.pop_front()));
            else                  chk("seg_unexp", 32'(seg_en), 32'(prev_seg));
        end
        prev_seg <= seg_en;
    end

    initial begin
        int n;
        int k;

        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_seg",   32'(seg_en),    32'd0);
        chk("rst_iso",   32'(iso),       32'd1);
        chk("rst_ready", 32'(ready),     32'd0);
        chk("rst_fault", 32'(fault),     32'd0);
        chk("rst_fseg",  32'(fault_seg), 32'd0);
        chk("rst_ring",  32'(ring_ctrl), 32'h08);

        // Normal power-up with latency measured from the sampling edge of pgood
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_seg0", 32'(seg_en), 32'd1);
        for (int i = 0; i < NSEG; i++) begin
            k = 0;
            while (!pgood[i] && k < 50) begin
                tick();
                k++;
            end
            chk("t1_iso_held", 32'(iso), 32'd1);
            n = 0;
            if (i < NSEG - 1) begin
                while (!seg_en[i+1] && n < 50) begin
                    tick();
                    n++;
                end
                chk("t1_step_lat", 32'(n), 32'(2 + SETTLE));
            end else begin
                while (iso && n < 50) begin
                    tick();
                    n++;
                end
                chk("t1_iso_lat", 32'(n), 32'(2 + SETTLE));
                chk("t1_rel_ready", 32'(ready), 32'd0);
            end
        end
        tick();
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_ring", 32'(ring_ctrl), 32'h17);

        // Power-down with a start pulse ignored mid-way
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_iso", 32'(iso), 32'd1);
        chk("t4_ready", 32'(ready), 32'd0);
        n = 0;
        while (seg_en !== 3'b011 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_gap2", 32'(n), 32'(SETTLE));
        n = 0;
        start = 1'b1;
        tick();
        n++;
        start = 1'b0;
        while (seg_en !== 3'b001 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_gap1", 32'(n), 32'(SETTLE));
        n = 0;
        while (seg_en !== 3'b000 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_gap0", 32'(n), 32'(SETTLE));
        repeat (6) tick();
        chk("t4_idle_seg", 32'(seg_en), 32'd0);
        chk("t4_idle_iso", 32'(iso), 32'd1);

        // Runtime loss of segment 2 for one cycle
        power_up("t3_ready");
        exp_q.push_back(3'b000);
        drop = 3'b100;
        tick();
        drop = '0;
        n = 1;
        while (!fault && n < 20) begin
            tick();
            n++;
        end
        chk("t3_lat", 32'(n), 32'd3);
        chk("t3_fseg", 32'(fault_seg), 32'd2);
        chk("t3_ready", 32'(ready), 32'd0);
        chk("t3_ring", 32'(ring_ctrl), 32'h08);
        pulse_clear();
        chk("t3_clear", 32'(fault), 32'd0);

        // Timeout on segment 1
        allow = 3'b101;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b000);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_seg("t2_seg1", 3'b011);
        n = 0;
        while (!fault && n < 40) begin
            tick();
            n++;
        end
        chk("t2_lat", 32'(n), 32'(TIMEOUT));
        chk("t2_fseg", 32'(fault_seg), 32'd1);
        chk("t2_seg", 32'(seg_en), 32'd0);
        chk("t2_iso", 32'(iso), 32'd1);
        allow = '1;
        pulse_clear();
        chk("t2_clear", 32'(fault), 32'd0);

        // stop coincides with a pgood[1] loss as seen by the state machine
        power_up("t5_ready");
        exp_q.push_back(3'b000);
        drop = 3'b010;
        tick();
        drop = '0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_fseg", 32'(fault_seg), 32'd1);
        chk("t5_iso", 32'(iso), 32'd1);
        pulse_clear();

        // start and stop together in IDLE begin power-up
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_both", 32'(seg_en), 32'd1);
        wait_seg("t6_pre", 3'b011);

        // Reset mid-PWRUP, then a clean sequence
        exp_q.push_back(3'b000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_seg", 32'(seg_en), 32'd0);
        chk("t6_iso", 32'(iso), 32'd1);
        chk("t6_ready", 32'(ready), 32'd0);
        chk("t6_fault", 32'(fault), 32'd0);
        repeat (2) tick();
        power_up("t6_ready");
        chk("t6_ring", 32'(ring_ctrl), 32'h17);

        tick();
        chk("seg_q_left", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
